// File: rtl/result_packer.sv
// result_packer: packs 16-bit engine results into LANES-wide words queued in a show-ahead FIFO for DMA write-back
module result_packer #(
    parameter int LANES = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           base_addr,
    input  logic [15:0]           result,
    input  logic                  result_wr_en,
    input  logic                  op_done,
    input  logic                  wb_ready,
    output logic                  wb_valid,
    output logic [16*LANES-1:0]   wb_data,
    output logic [LANES-1:0]      wb_mask,
    output logic [31:0]           wb_addr,
    output logic                  full,
    output logic                  flush_done,
    output logic                  overflow,
    output logic [15:0]           word_count
);
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t              state;
    logic [LW-1:0]       lane_cnt;
    logic [16*LANES-1:0] asm_data;
    logic [16*LANES-1:0] new_data;
    logic [LANES-1:0]    asm_mask;
    logic [LANES-1:0]    new_mask;
    logic                pend;
    logic [16*LANES-1:0] mem_data [DEPTH];
    logic [LANES-1:0]    mem_mask [DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       count;
    logic                wr_run;
    logic                lane_last;
    logic                push;
    logic                pop;
    logic                do_push;
    logic                drop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign wr_run    = state == RUN && result_wr_en;
    assign lane_last = lane_cnt == LW'(LANES - 1);
    assign push      = (wr_run && lane_last) || (state == FLUSH && pend);
    assign wb_valid  = count != '0;
    assign full      = count == CW'(DEPTH);
    assign pop       = wb_valid && wb_ready;
    assign do_push   = push && (!full || pop);
    assign drop      = push && !do_push;
    assign wb_data   = wb_valid ? mem_data[rd_ptr] : '0;
    assign wb_mask   = wb_valid ? mem_mask[rd_ptr] : '0;

    // Place the incoming result into its lane; lanes not yet filled read as zero in the assembled word
    always_comb begin
        new_data = '0;
        new_mask = asm_mask;
        for (int k = 0; k < LANES; k++) begin
            new_mask[k] = asm_mask[k] || (wr_run && lane_cnt == LW'(k));
            new_data[16*k +: 16] = !new_mask[k] ? 16'h0 :
                                   (wr_run && lane_cnt == LW'(k)) ? result : asm_data[16*k +: 16];
        end
    end

    // Control FSM with lane assembly, head address, word counter and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            lane_cnt   <= '0;
            asm_data   <= '0;
            asm_mask   <= '0;
            pend       <= 1'b0;
            wb_addr    <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (pop) begin
                wb_addr    <= wb_addr + 32'd16;
                word_count <= word_count + 1'b1;
            end
            if (drop)
                overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        wb_addr    <= base_addr;
                        lane_cnt   <= '0;
                        asm_mask   <= '0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end else if (result_wr_en) begin
                        overflow <= 1'b1;
                    end
                end
                RUN: begin
                    if (result_wr_en) begin
                        asm_data <= new_data;
                        lane_cnt <= lane_last ? '0 : lane_cnt + 1'b1;
                        asm_mask <= lane_last ? '0 : new_mask;
                    end
                    if (op_done) begin
                        state <= FLUSH;
                        pend  <= wr_run ? !lane_last : lane_cnt != '0;
                    end
                end
                default: begin
                    if (result_wr_en)
                        overflow <= 1'b1;
                    if (pend) begin
                        pend     <= 1'b0;
                        lane_cnt <= '0;
                        asm_mask <= '0;
                    end else if (count == '0) begin
                        state      <= IDLE;
                        flush_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a push into a full FIFO lands only when the head pops in the same cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(pop);
        end
    end

    // FIFO storage; contents are only observable while the occupancy is nonzero
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wr_ptr] <= new_data;
            mem_mask[wr_ptr] <= new_mask;
        end
    end
endmodule
